// File: rtl/cos_sequencer.sv
// Range-reduces Q10 angles to [0, pi/2] + sign, drives the cosine engine, signs its result.
// Latency: 9 cycles accept->out_valid, +1 per 2*pi reduction; timeout path TIMEOUT+1 after WAIT entry.
// Backpressure: in_ready only in IDLE; result held on out_valid until out_ready.
module cos_sequencer #(
  parameter int W               = 24,
  parameter int PI_Q            = 3217,
  parameter int HALF_PI_Q       = 1608,
  parameter int THREE_HALF_PI_Q = 4825,
  parameter int TWO_PI_Q        = 6434,
  parameter int TIMEOUT         = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] angle_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] cos_out,
  output logic         out_err,
  output logic         eng_start,
  output logic [W-1:0] eng_angle,
  input  logic         eng_ready,
  input  logic [W-1:0] eng_cos
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]   PI_V     = W'(PI_Q);
  localparam logic [W-1:0]   HALF_V   = W'(HALF_PI_Q);
  localparam logic [W-1:0]   THREE_V  = W'(THREE_HALF_PI_Q);
  localparam logic [W-1:0]   TWO_PI_V = W'(TWO_PI_Q);
  localparam logic [WDW-1:0] WD_LIM   = WDW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_REDUCE, S_FOLD, S_START, S_WAIT, S_OUT
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a, a_nxt;
  logic [W-1:0]   cos_nxt, eng_angle_nxt;
  logic           neg, neg_nxt;
  logic           st_cnt, st_cnt_nxt;
  logic           out_valid_nxt, out_err_nxt, eng_start_nxt;
  logic [WDW-1:0] wd, wd_nxt;

  assign in_ready = (state == S_IDLE) & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      a         <= '0;
      neg       <= 1'b0;
      st_cnt    <= 1'b0;
      wd        <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      cos_out   <= '0;
      eng_start <= 1'b0;
      eng_angle <= '0;
    end else begin
      state     <= state_nxt;
      a         <= a_nxt;
      neg       <= neg_nxt;
      st_cnt    <= st_cnt_nxt;
      wd        <= wd_nxt;
      out_valid <= out_valid_nxt;
      out_err   <= out_err_nxt;
      cos_out   <= cos_nxt;
      eng_start <= eng_start_nxt;
      eng_angle <= eng_angle_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    a_nxt         = a;
    neg_nxt       = neg;
    st_cnt_nxt    = st_cnt;
    wd_nxt        = wd;
    out_valid_nxt = out_valid;
    out_err_nxt   = out_err;
    cos_nxt       = cos_out;
    eng_start_nxt = eng_start;
    eng_angle_nxt = eng_angle;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          a_nxt     = angle_in;
          state_nxt = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (a >= TWO_PI_V) a_nxt = a - TWO_PI_V;
        else               state_nxt = S_FOLD;
      end
      S_FOLD: begin
        // eng_angle doubles as the reduced-angle register x
        if (a <= HALF_V) begin
          eng_angle_nxt = a;
          neg_nxt       = 1'b0;
        end else if (a <= PI_V) begin
          eng_angle_nxt = PI_V - a;
          neg_nxt       = 1'b1;
        end else if (a <= THREE_V) begin
          eng_angle_nxt = a - PI_V;
          neg_nxt       = 1'b1;
        end else begin
          eng_angle_nxt = TWO_PI_V - a;
          neg_nxt       = 1'b0;
        end
        eng_start_nxt = 1'b1;
        st_cnt_nxt    = 1'b0;
        state_nxt     = S_START;
      end
      S_START: begin
        // engine's stale ready from the previous op is still high here
        if (st_cnt) begin
          wd_nxt    = '0;
          state_nxt = S_WAIT;
        end else begin
          st_cnt_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (eng_ready) begin
          cos_nxt       = neg ? ({W{1'b0}} - eng_cos) : eng_cos;
          out_err_nxt   = 1'b0;
          out_valid_nxt = 1'b1;
          eng_start_nxt = 1'b0;
          state_nxt     = S_OUT;
        end else if (wd == WD_LIM) begin
          cos_nxt       = '0;
          out_err_nxt   = 1'b1;
          out_valid_nxt = 1'b1;
          eng_start_nxt = 1'b0;
          state_nxt     = S_OUT;
        end else if (wd != '1) begin
          wd_nxt = wd + WDW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cos_sequencer.sv
// Random and directed checks of cos_sequencer against an arithmetic reference model,
// with a behavioural cosine engine (fixed handshake timing, optional extra delay or no response).
module tb_cos_sequencer;

  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] angle_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] cos_out;
  logic        out_err;
  logic        eng_start;
  logic [23:0] eng_angle;
  logic        eng_ready;
  logic [23:0] eng_cos;

  int total = 0;
  int bad   = 0;

  cos_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_in  (angle_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out),
    .out_err   (out_err),
    .eng_start (eng_start),
    .eng_angle (eng_angle),
    .eng_ready (eng_ready),
    .eng_cos   (eng_cos)
  );

  always #5 clock = ~clock;

  // Stand-in engine transfer function: 1 - x^2/2 in Q10
  function automatic int eng_fn(input int x);
    return 1024 - (x * x) / 2048;
  endfunction

  // Engine: samples start once per operation, drops ready next cycle, answers 5+extra cycles after sampling
  bit          eng_dead  = 1'b0;
  int          eng_extra = 0;
  logic        eng_busy;
  logic        eng_armed;
  int          eng_phase;
  logic [23:0] eng_lat;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      eng_ready <= 1'b0;
      eng_cos   <= '0;
      eng_busy  <= 1'b0;
      eng_armed <= 1'b1;
      eng_phase <= 0;
      eng_lat   <= '0;
    end else if (eng_busy) begin
      eng_phase <= eng_phase + 1;
      if (eng_phase == 0) eng_ready <= 1'b0;
      if (!eng_start) begin
        eng_busy  <= 1'b0;
        eng_armed <= 1'b1;
      end else if (!eng_dead && eng_phase == 4 + eng_extra) begin
        int v;
        v = eng_fn(int'(eng_lat));
        eng_ready <= 1'b1;
        eng_cos   <= v[23:0];
        eng_busy  <= 1'b0;
      end
    end else if (eng_start && eng_armed) begin
      eng_busy  <= 1'b1;
      eng_armed <= 1'b0;
      eng_phase <= 0;
      eng_lat   <= eng_angle;
    end else if (!eng_start) begin
      eng_armed <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole 2*pi turns removed, then quadrant fold
  task automatic model(input int ang, output int k, output int x, output bit neg);
    int r;
    k = ang / 6434;
    r = ang % 6434;
    if (r <= 1608)      begin x = r;        neg = 1'b0; end
    else if (r <= 3217) begin x = 3217 - r; neg = 1'b1; end
    else if (r <= 4825) begin x = r - 3217; neg = 1'b1; end
    else                begin x = 6434 - r; neg = 1'b0; end
  endtask

  task automatic do_op(input int ang, input bit dead, input int extra, input int bp);
    int k, x, n, exp_lat, e;
    bit neg, got;
    logic [23:0] exp_cos;
    model(ang, k, x, neg);
    e       = neg ? -eng_fn(x) : eng_fn(x);
    exp_cos = dead ? 24'd0 : e[23:0];
    exp_lat = dead ? (4 + k + TIMEOUT + 1) : (9 + k + extra);
    eng_dead  = dead;
    eng_extra = extra;

    @(negedge clock);
    in_valid = 1'b1;
    angle_in = ang[23:0];
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin got = 1'b1; break; end
      @(negedge clock);
    end
    chk("accept", 32'(got), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    angle_in = 24'($urandom);

    n = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      n++;
      if (out_valid) begin got = 1'b1; break; end
    end
    chk("out_valid_seen", 32'(got), 32'd1);
    chk("latency", n, exp_lat);
    chk("cos_out", 32'(cos_out), 32'(exp_cos));
    chk("out_err", 32'(out_err), 32'(dead));
    chk("eng_start_low", 32'(eng_start), 32'd0);
    chk("eng_angle", 32'(eng_angle), x);
    chk("in_ready_busy", 32'(in_ready), 32'd0);

    for (int i = 0; i < bp; i++) begin
      @(posedge clock);
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_cos", 32'(cos_out), 32'(exp_cos));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end

    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    angle_in  = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_cos_out", 32'(cos_out), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_eng_angle", 32'(eng_angle), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed: zero, quadrant boundaries, multi-turn reductions
    do_op(0, 1'b0, 0, 0);
    do_op(3217, 1'b0, 0, 0);
    do_op(6434, 1'b0, 0, 0);
    do_op(12868, 1'b0, 0, 0);
    do_op(4825, 1'b0, 0, 0);
    do_op(1608, 1'b0, 0, 0);
    do_op(1609, 1'b0, 0, 0);
    do_op(4826, 1'b0, 0, 0);

    // Engine never answers, then a normal op
    do_op(1000, 1'b1, 0, 0);
    do_op(500, 1'b0, 0, 0);

    // Output backpressure
    do_op(2000, 1'b0, 0, 5);

    // Reset pulse while waiting on the engine
    eng_dead  = 1'b0;
    eng_extra = 5;
    @(negedge clock);
    in_valid = 1'b1;
    angle_in = 24'd700;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_wait_eng_start", 32'(eng_start), 32'd0);
    chk("rst_wait_out_valid", 32'(out_valid), 32'd0);
    chk("rst_wait_in_ready", 32'(in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    do_op(300, 1'b0, 0, 0);

    // Random angles, engine delays and backpressure
    for (int t = 0; t < 25; t++) begin
      do_op(int'($urandom_range(40000, 0)), 1'b0, int'($urandom_range(4, 0)),
            int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cos_sequencer.md
# cos_sequencer

Front-end initiator for the Taylor cosine engine. Accepts arbitrary non-negative Q10 angles on a valid/ready input stream and reduces each angle to [0, π/2] with a quadrant sign. It drives the engine's start/angle_in/ready_out/cos_out handshake, applies the sign to the result, and returns it on a valid/ready output stream. It sits between the angle source and the engine, and owns all handshake sequencing and the watchdog.

## Interface
- W, 24: data width, all angle/cosine buses
- PI_Q, 3217: π in Q10
- HALF_PI_Q, 1608: π/2 in Q10
- THREE_HALF_PI_Q, 4825: 3π/2 in Q10
- TWO_PI_Q, 6434: 2π in Q10
- TIMEOUT, 64: max WAIT cycles before abort
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- in_valid  in  1  angle_in valid
- in_ready  out  1  high only in IDLE and reset low
- angle_in  in  W  unsigned Q10 angle
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  downstream accepts
- cos_out  out  W  signed Q10 cosine (two's complement)
- out_err  out  1  qualifies out_valid: 1 = engine timeout, cos_out = 0
- eng_start  out  1  to engine start
- eng_angle  out  W  to engine angle_in, reduced angle x
- eng_ready  in  1  from engine ready_out
- eng_cos  in  W  from engine cos_out

## Operation
- Reset values: out_valid 0, out_err 0, cos_out 0, eng_start 0, eng_angle 0, state IDLE. in_ready is 0 while reset is high.
- IDLE: on in_valid & in_ready, register angle_in into a, go to REDUCE.
- REDUCE: if a ≥ TWO_PI_Q, a ← a − TWO_PI_Q and stay (one subtraction per cycle); else go to FOLD.
- FOLD: register x and neg, then go to START.
  - a ≤ HALF_PI_Q: x=a, neg=0
  - a ≤ PI_Q: x=PI_Q−a, neg=1
  - a ≤ THREE_HALF_PI_Q: x=a−PI_Q, neg=1
  - else: x=TWO_PI_Q−a, neg=0
- START: eng_start=1, eng_angle=x, held for exactly 2 cycles. eng_ready is ignored here because the engine's ready from the previous op stays high until the engine clears it. Then go to WAIT.
- WAIT: eng_start stays 1 and eng_angle is held.
  - On eng_ready=1: cos_out ← neg ? −eng_cos : eng_cos (W-bit two's complement, wrap), out_err ← 0, eng_start ← 0, go to OUT.
  - If the watchdog reaches TIMEOUT with no eng_ready: cos_out ← 0, out_err ← 1, eng_start ← 0, go to OUT.
- OUT: out_valid=1. cos_out and out_err are stable until out_ready=1, then out_valid ← 0 and go to IDLE.
- eng_start is low for at least 4 cycles between consecutive operations (OUT, IDLE, REDUCE, FOLD). This guarantees the engine returns to its idle state.
- Watchdog: counter cleared on entry to WAIT, increments each WAIT cycle, saturates; compares equal to TIMEOUT.
- Reset mid-operation, in any state: immediate return to reset values. A pending output is discarded and eng_start drops asynchronously. The engine shares the same reset net.
- Boundaries: a=HALF_PI_Q → first quadrant. a=PI_Q → x=0, neg=1. a=THREE_HALF_PI_Q → x=HALF_PI_Q, neg=1. a=TWO_PI_Q → reduces to 0.

## Timing
- Accept edge a0 (in_valid & in_ready); REDUCE evaluated at a1; FOLD at a2.
- eng_start visible after a2.
- Engine sees start at a3 and clears its ready at a4. WAIT is entered at a4.
- Engine ready rises after a8. WAIT samples it at a9, and out_valid is high after a9.
- Latency: 9 cycles from accept edge to out_valid for angle < TWO_PI_Q, plus 1 cycle per extra reduction. k reductions → 9+k.
- Timeout path: out_valid high TIMEOUT+1 cycles after WAIT entry.
- in_ready is low from a0 until the cycle after the out_valid/out_ready handshake. Throughput: one operation per ≥10 cycles.
- All outputs are registered except in_ready (state==IDLE & ~reset).

## Test plan
- angle_in=0 with the real engine → eng_angle=0, neg=0; out_valid 9 cycles after accept; cos_out=1024, out_err=0.
- angle_in=3217 (π) → eng_angle=0, neg=1; cos_out=0xFFFC00 (−1024).
- angle_in=6434 (2π) → one REDUCE iteration; cos_out=1024; latency 10. angle_in=12868 → latency 11, same result.
- angle_in=4825 → eng_angle=1608, neg=1; cos_out = −(engine result for 1608). angle_in=1608 → eng_angle=1608, neg=0.
- Engine model holds eng_ready=0 → after 64 WAIT cycles: out_valid=1, out_err=1, cos_out=0, eng_start=0. The next operation then completes normally.
- Backpressure: out_ready=0 for 5 cycles → out_valid and cos_out stable, in_ready=0. Reset pulse asserted in WAIT → eng_start=0 and out_valid=0 immediately, then a clean operation after release.
